// File: rtl/sdr_pkg.sv
// sdr_pkg: constants and helpers shared by the SDRAM read and write data paths.
`default_nettype none

package sdr_pkg;

   localparam int unsigned CL_MIN     = 2;
   localparam int unsigned CL_MAX     = 3;
   localparam int unsigned BL_1       = 1;
   localparam int unsigned BL_2       = 2;
   localparam int unsigned BL_4       = 4;
   localparam int unsigned BL_8       = 8;
   localparam int unsigned DW_DEFAULT = 16;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sdr_rd_fifo.sv
// sdr_rd_fifo: synchronous show-ahead FIFO holding captured read words for the host.
`default_nettype none

module sdr_rd_fifo
   import sdr_pkg::*;
#(
   parameter int unsigned DW    = DW_DEFAULT,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   push_i,
   input  logic [DW-1:0]          push_data_i,
   input  logic                   pop_i,
   output logic [DW-1:0]          pop_data_o,
   output logic [clog2(DEPTH):0]  level_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   level_q;
   logic          do_pop_w;
   logic          do_push_w;

   assign empty_o    = (level_q == '0);
   assign full_o     = (level_q == (AW+1)'(DEPTH));
   assign do_pop_w   = pop_i && !empty_o;
   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign do_push_w  = push_i && (!full_o || do_pop_w);
   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign level_o    = level_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push_w && !do_pop_w)      level_q <= level_q + 1'b1;
         else if (do_pop_w && !do_push_w) level_q <= level_q - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push_w) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

`default_nettype wire

// File: rtl/sdr_read_capture.sv
// sdr_read_capture: expands READ commands into CL-delayed beat strobes, captures DQ
// on those edges and hands the words to the host through a show-ahead FIFO.
`default_nettype none

module sdr_read_capture
   import sdr_pkg::*;
#(
   parameter int unsigned CL    = 3,
   parameter int unsigned BL    = 4,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = DW_DEFAULT
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   RD_CMD,
   input  logic [DW-1:0]          DQIN,
   input  logic                   RD_READY,
   output logic [DW-1:0]          RD_DATA,
   output logic                   RD_VALID,
   output logic [clog2(DEPTH):0]  LEVEL,
   output logic                   BUSY,
   output logic                   OVERFLOW
);

   localparam int unsigned CW = clog2(BL) + 1;

   logic [CW-1:0] beat_cnt_q;
   logic [CL-1:0] dline_q;
   logic [DW-1:0] cap_q;
   logic          cap_vld_q;
   logic          ovf_q;
   logic          expect_w;
   logic          full_w;
   logic          empty_w;

   // the command cycle carries beat 0 itself; the counter holds the beats still owed
   assign expect_w = RD_CMD || (beat_cnt_q != '0);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         beat_cnt_q <= '0;
         dline_q    <= '0;
         cap_q      <= '0;
         cap_vld_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (RD_CMD)                  beat_cnt_q <= CW'(BL - 1);
         else if (beat_cnt_q != '0)   beat_cnt_q <= beat_cnt_q - 1'b1;
         dline_q   <= {dline_q[CL-2:0], expect_w};
         cap_vld_q <= dline_q[CL-1];
         if (dline_q[CL-1]) cap_q <= DQIN;
         // full implies non-empty, so RD_READY alone decides whether a slot opens
         if (cap_vld_q && full_w && !RD_READY) ovf_q <= 1'b1;
      end
   end

   sdr_rd_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .push_i      (cap_vld_q),
      .push_data_i (cap_q),
      .pop_i       (RD_READY),
      .pop_data_o  (RD_DATA),
      .level_o     (LEVEL),
      .full_o      (full_w),
      .empty_o     (empty_w)
   );

   assign RD_VALID = !empty_w;
   assign BUSY     = (beat_cnt_q != '0) || (|dline_q) || cap_vld_q;
   assign OVERFLOW = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sdr_read_capture.sv
// tb_sdr_read_capture: scoreboard bench; a cycle-indexed command/DQ history model predicts
// which words reach the host, the FIFO level, BUSY and the sticky overflow flag.
`default_nettype none

module tb_sdr_read_capture;
   import sdr_pkg::*;

   localparam int CL    = 3;
   localparam int BL    = 4;
   localparam int DEPTH = 8;
   localparam int DW    = 16;
   localparam int LW    = clog2(DEPTH) + 1;

   logic          CLK      = 1'b0;
   logic          RESET_N  = 1'b0;
   logic          RD_CMD   = 1'b0;
   logic          RD_READY = 1'b0;
   logic [DW-1:0] DQIN     = '0;
   logic [DW-1:0] RD_DATA;
   logic          RD_VALID;
   logic [LW-1:0] LEVEL;
   logic          BUSY;
   logic          OVERFLOW;

   always #5 CLK = ~CLK;

   sdr_read_capture #(.CL(CL), .BL(BL), .DEPTH(DEPTH), .DW(DW)) dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .RD_CMD   (RD_CMD),
      .DQIN     (DQIN),
      .RD_READY (RD_READY),
      .RD_DATA  (RD_DATA),
      .RD_VALID (RD_VALID),
      .LEVEL    (LEVEL),
      .BUSY     (BUSY),
      .OVERFLOW (OVERFLOW)
   );

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] exp_q[$];
   bit            cmd_a [0:4095];
   int            cyc;
   int            m_lvl;
   bit            m_ovf;
   bit            m_capv;
   logic [DW-1:0] m_capw;

   function automatic bit cmd_in(int lo, int hi);
      for (int t = lo; t <= hi; t++) if (t >= 0 && cmd_a[t]) return 1'b1;
      return 1'b0;
   endfunction

   // a beat is owed in cycle c iff a READ was issued within the last BL cycles
   function automatic bit beat(int c);
      return (c >= 0) && cmd_in(c - BL + 1, c);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // model of what happens at the clock edge ending cycle cyc
   task automatic model_edge(bit rdy, logic [DW-1:0] dq);
      int nl;
      nl = m_lvl - ((m_lvl > 0 && rdy) ? 1 : 0);
      if (m_capv) begin
         if (nl < DEPTH) begin
            exp_q.push_back(m_capw);
            nl++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_lvl  = nl;
      m_capv = beat(cyc - CL);
      if (m_capv) m_capw = dq;
   endtask

   task automatic cycle(bit cmd, logic [DW-1:0] dq, bit rdy);
      RD_CMD   = cmd;
      DQIN     = dq;
      RD_READY = rdy;
      cmd_a[cyc] = cmd;
      @(posedge CLK);
      model_edge(rdy, dq);
      cyc++;
      #2;
   endtask

   task automatic do_reset();
      RESET_N  = 1'b0;
      RD_CMD   = 1'b0;
      RD_READY = 1'b0;
      cyc    = 0;
      m_lvl  = 0;
      m_ovf  = 1'b0;
      m_capv = 1'b0;
      exp_q.delete();
      foreach (cmd_a[i]) cmd_a[i] = 1'b0;
      repeat (2) @(posedge CLK);
      #2;
      RESET_N = 1'b1;
   endtask

   always @(negedge CLK) begin
      bit b;
      if (!RESET_N) begin
         chk("rst_valid", 32'(RD_VALID), 32'd0);
         chk("rst_data",  32'(RD_DATA),  32'd0);
         chk("rst_level", 32'(LEVEL),    32'd0);
         chk("rst_busy",  32'(BUSY),     32'd0);
         chk("rst_ovf",   32'(OVERFLOW), 32'd0);
      end else begin
         b = cmd_in(cyc - BL + 1, cyc - 1);
         for (int k = 1; k <= CL + 1; k++) if (beat(cyc - k)) b = 1'b1;
         chk("valid",    32'(RD_VALID), 32'(m_lvl > 0));
         chk("level",    32'(LEVEL),    32'(m_lvl));
         chk("busy",     32'(BUSY),     32'(b));
         chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
         if (RD_VALID && RD_READY) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_data: got %0h expected no word (cycle %0d)", RD_DATA, cyc);
            end else begin
               chk("pop_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      do_reset();

      // single burst, known data on the capture cycles
      for (int c = 0; c < 14; c++)
         cycle(c == 0, (c >= 3 && c <= 6) ? DW'(16'h1111 * (c - 2)) : DW'($urandom), 1'b1);

      // read interrupting read
      for (int c = 0; c < 16; c++)
         cycle(c == 0 || c == 2, DW'($urandom), 1'b1);

      // three bursts into a stalled host: saturation and sticky overflow
      do_reset();
      for (int c = 0; c < 22; c++)
         cycle(c == 0 || c == 4 || c == 8, DW'($urandom), 1'b0);
      for (int c = 0; c < 12; c++)
         cycle(1'b0, DW'($urandom), 1'b1);

      // full FIFO with a pop on every push cycle: no overflow
      do_reset();
      for (int c = 0; c < 26; c++)
         cycle(c == 0 || c == 4 || c == 14, DW'($urandom), c >= 18 && c <= 21);
      for (int c = 0; c < 12; c++)
         cycle(1'b0, DW'($urandom), 1'b1);

      // reset in the middle of a burst, then quiet bus activity only
      for (int c = 0; c < 4; c++)
         cycle(c == 0, DW'($urandom), 1'b1);
      do_reset();
      for (int c = 0; c < 20; c++)
         cycle(1'b0, DW'($urandom), 1'b1);

      // random traffic
      for (int c = 0; c < 400; c++)
         cycle($urandom_range(0, 4) == 0, DW'($urandom), $urandom_range(0, 3) != 0);
      for (int c = 0; c < 20; c++)
         cycle(1'b0, DW'($urandom), 1'b1);
      chk("drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
